// File: rtl/state_packer.sv
// state_packer: stamps each accepted input byte with a wrapping sequencer
// state, its bitwise complement and a constant token, then queues the
// resulting record in a small FIFO for a ready/valid consumer.
//
// Record layout (MSB first): {state[31:0], ~data, data, TOKEN}
//
// Ports
//   clock       sole clock, rising edge
//   clear_n     asynchronous active-low reset
//   flush       synchronous clear of buffer and sequencer (beats push/pop)
//   in_valid    input beat offered
//   in_ready    input beat accepted when high together with in_valid
//   in_data     input payload
//   out_valid   buffer head holds a record
//   out_ready   consumer takes the head when high together with out_valid
//   out_record  buffer head record
//   out_check   head record state field is zero
//   occupancy   records currently held (0..DEPTH)
module state_packer #(
  parameter int unsigned          DATA_W     = 8,
  parameter int unsigned          TOKEN_W    = 16,
  parameter logic [TOKEN_W-1:0]   TOKEN      = 16'hABCD,
  parameter longint unsigned      NUM_STATES = 2,
  parameter int unsigned          DEPTH      = 2,
  localparam int unsigned         REC_W      = 32 + 2 * DATA_W + TOKEN_W,
  localparam int unsigned         CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_record,
  output logic              out_check,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Sequencer and buffer bookkeeping.
  logic [31:0]      cur_state_q, cur_state_d, next_state;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Low while in reset and until the first edge after release, so the
  // input side stays closed for that window.
  logic             alive_q;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] new_record;

  logic             full;
  logic             push;
  logic             pop;
  logic             last_state;

  // ---------------------------------------------------------------------------
  // Sequencer next value, wrapping NUM_STATES-1 -> 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    last_state = ({32'd0, cur_state_q} == (NUM_STATES - 64'd1));
    next_state = last_state ? 32'd0 : (cur_state_q + 32'd1);
  end

  assign new_record = {next_state, ~in_data, in_data, TOKEN};

  // ---------------------------------------------------------------------------
  // Handshakes. in_ready depends only on registered state and flush; a pop in
  // the same cycle never opens a slot for a push while full.
  // ---------------------------------------------------------------------------
  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = alive_q && !full && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state for pointers, count and sequencer. Flush wins over everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_state_d = cur_state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (flush) begin
      cur_state_d = 32'd0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end else begin
      if (push) begin
        cur_state_d = next_state;
        wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cur_state_q <= 32'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      alive_q     <= 1'b0;
    end else begin
      cur_state_q <= cur_state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      alive_q     <= 1'b1;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_record;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. Reading straight from the head slot keeps out_record
  // stable whenever the read pointer does not move.
  // ---------------------------------------------------------------------------
  assign out_record = mem_q[rd_ptr_q];
  assign out_check  = (out_record[REC_W-1 -: 32] == 32'd0);
  assign occupancy  = count_q;

  // Occupancy never exceeds the buffer size.
  a_count_bound : assert property (@(posedge clock) disable iff (!clear_n)
    count_q <= CNT_W'(DEPTH));

  // A push while full would overwrite the head.
  a_no_push_full : assert property (@(posedge clock) disable iff (!clear_n)
    full |-> !push);

endmodule

// File: tb/tb_state_packer.sv
// Bench for state_packer: two instances share stimulus (defaults, and
// NUM_STATES=3 / DEPTH=4). A queue-based model predicts every output.
module tb_state_packer;

  localparam int unsigned     DA = 2;
  localparam int unsigned     DB = 4;
  localparam longint unsigned NA = 2;
  localparam longint unsigned NB = 3;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        a_in_ready, a_out_valid, a_out_check;
  logic [63:0] a_out_record;
  logic [1:0]  a_occ;
  logic        b_in_ready, b_out_valid, b_out_check;
  logic [63:0] b_out_record;
  logic [2:0]  b_occ;

  state_packer #(.NUM_STATES(NA), .DEPTH(DA)) u_dut_a (
    .clock      (clock),
    .clear_n    (clear_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (a_in_ready),
    .in_data    (in_data),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_record (a_out_record),
    .out_check  (a_out_check),
    .occupancy  (a_occ)
  );

  state_packer #(.NUM_STATES(NB), .DEPTH(DB)) u_dut_b (
    .clock      (clock),
    .clear_n    (clear_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (b_in_ready),
    .in_data    (in_data),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_record (b_out_record),
    .out_check  (b_out_check),
    .occupancy  (b_occ)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: one queue of records and one state counter per instance.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [31:0] sa = 32'd0;
  logic [31:0] sb = 32'd0;
  bit          alive = 1'b0;

  function automatic logic [63:0] mk(input logic [31:0] s, input logic [7:0] d);
    return {s, ~d, d, 16'hABCD};
  endfunction

  task automatic cmp(input string who, input logic rdy, input logic vld, input int occ,
                     input logic [63:0] rec, input logic chk, input int size,
                     input logic [63:0] head, input int depth);
    check({who, ".in_ready"},  64'(rdy), 64'(alive && (size < depth) && !flush));
    check({who, ".out_valid"}, 64'(vld), 64'(size != 0));
    check({who, ".occupancy"}, 64'(occ), 64'(size));
    if (size != 0) begin
      check({who, ".out_record"}, rec, head);
      check({who, ".out_check"},  64'(chk), 64'(head[63:32] == 32'd0));
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit pa, pb, ppa, ppb;
    @(negedge clock);
    cmp("a", a_in_ready, a_out_valid, int'(a_occ), a_out_record, a_out_check,
        qa.size(), (qa.size() != 0) ? qa[0] : 64'd0, DA);
    cmp("b", b_in_ready, b_out_valid, int'(b_occ), b_out_record, b_out_check,
        qb.size(), (qb.size() != 0) ? qb[0] : 64'd0, DB);
    pa  = alive && (qa.size() < DA) && !flush && in_valid;
    pb  = alive && (qb.size() < DB) && !flush && in_valid;
    ppa = (qa.size() != 0) && out_ready;
    ppb = (qb.size() != 0) && out_ready;
    @(posedge clock);
    if (flush) begin
      qa.delete(); qb.delete();
      sa = 32'd0; sb = 32'd0;
    end else begin
      if (ppa) void'(qa.pop_front());
      if (ppb) void'(qb.pop_front());
      if (pa) begin
        sa = 32'((64'(sa) + 64'd1) % NA);
        qa.push_back(mk(sa, in_data));
      end
      if (pb) begin
        sb = 32'((64'(sb) + 64'd1) % NB);
        qb.push_back(mk(sb, in_data));
      end
    end
    alive = 1'b1;
    #1;
  endtask

  // Reset pulse between edges; outputs must drop at once.
  task automatic pulse_reset();
    clear_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    sa = 32'd0; sb = 32'd0;
    alive = 1'b0;
    check("rst.a.out_valid", 64'(a_out_valid), 64'd0);
    check("rst.a.occupancy", 64'(a_occ), 64'd0);
    check("rst.a.in_ready",  64'(a_in_ready), 64'd0);
    check("rst.b.out_valid", 64'(b_out_valid), 64'd0);
    check("rst.b.occupancy", 64'(b_occ), 64'd0);
    check("rst.b.in_ready",  64'(b_in_ready), 64'd0);
    #1;
    clear_n = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] exp39 [4];
    exp39[0] = 32'd1; exp39[1] = 32'd2; exp39[2] = 32'd0; exp39[3] = 32'd1;

    @(posedge clock); #1;
    pulse_reset();
    cycle();
    cycle();
    check("t034.a.in_ready", 64'(a_in_ready), 64'd1);

    // First push from reset.
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("t036.out_valid",  64'(a_out_valid), 64'd1);
    check("t036.out_record", a_out_record, {32'd1, 8'hA5, 8'h5A, 16'hABCD});
    check("t036.out_check",  64'(a_out_check), 64'd0);
    cycle();
    do_flush();

    // State field wraps to zero on the second push with NUM_STATES=2.
    in_valid = 1'b1; in_data = 8'h00;
    cycle();
    in_data = 8'hFF;
    cycle();
    in_valid = 1'b0;
    check("t037.rec0", a_out_record, {32'd1, 8'hFF, 8'h00, 16'hABCD});
    out_ready = 1'b1;
    cycle();
    check("t037.rec1",  a_out_record, {32'd0, 8'h00, 8'hFF, 16'hABCD});
    check("t037.check", 64'(a_out_check), 64'd1);
    cycle();
    do_flush();

    // Backpressure with a full buffer; third beat waits for a pop.
    in_valid = 1'b1; in_data = 8'h11;
    cycle();
    in_data = 8'h22;
    cycle();
    in_data = 8'h33;
    check("t038.in_ready",  64'(a_in_ready), 64'd0);
    check("t038.occupancy", 64'(a_occ), 64'd2);
    cycle();
    out_ready = 1'b1;
    cycle();
    check("t038.head2", a_out_record, {32'd0, 8'hDD, 8'h22, 16'hABCD});
    cycle();
    in_valid = 1'b0;
    check("t038.head3", a_out_record, {32'd1, 8'hCC, 8'h33, 16'hABCD});
    cycle();
    do_flush();

    // NUM_STATES=3 sequence on instance b.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h40 + i);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t039.state%0d", i), 64'(b_out_record[63:32]), 64'(exp39[i]));
      cycle();
    end
    do_flush();

    // Flush overrides a concurrent push.
    in_valid = 1'b1; in_data = 8'h77;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("t040.occupancy", 64'(a_occ), 64'd0);
    check("t040.out_valid", 64'(a_out_valid), 64'd0);
    in_valid = 1'b1; in_data = 8'h88;
    cycle();
    in_valid = 1'b0;
    check("t040.state", 64'(a_out_record[63:32]), 64'd1);
    cycle();

    // Reset mid-stream discards held records.
    in_valid = 1'b1; in_data = 8'h99;
    cycle();
    cycle();
    in_valid = 1'b0;
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle();
    check("t041.out_valid", 64'(a_out_valid), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) pulse_reset();
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
